hilo_wb_unit: RTL and testbench

Writeback-side counterpart to the decode/register-read stage of the single-clock MIPS core. It produces the register-file write data `Wdata` by selecting among the ALU result, load data, link address and HI/LO. It owns the HI/LO registers and an iterative multiply/divide sequencer, and asserts `Stall` so the core freezes PC while a HI/LO-dependent instruction waits for the sequencer.

---
 rtl/hilo_wb_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_hilo_wb_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_wb_unit.sv
// hilo_wb_unit: writeback data select, HI/LO registers and an iterative
// multiply/divide sequencer that stalls HI/LO-dependent instructions.
// Optional build macro: HILO_FAST_MUL_EN selects a single-cycle combinational
// multiplier for MULT/MULTU. Divides stay iterative in both builds.
module hilo_wb_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic [31:0] AluResult,
    input  logic [31:0] MemData,
    input  logic [31:0] PC4,
    output logic [31:0] Wdata,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Opcode / function encodings shared with the rest of the core.
    localparam logic [5:0] R_FORM = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] JAL    = 6'b000011;
    localparam logic [5:0] JALR   = 6'b001001;  // R_FORM function code
    localparam logic [5:0] MFHI   = 6'b010000;
    localparam logic [5:0] MTHI   = 6'b010001;
    localparam logic [5:0] MFLO   = 6'b010010;
    localparam logic [5:0] MTLO   = 6'b010011;
    localparam logic [5:0] MULT   = 6'b011000;
    localparam logic [5:0] MULTU  = 6'b011001;
    localparam logic [5:0] DIV    = 6'b011010;
    localparam logic [5:0] DIVU   = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;   // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q, opnd_d;   // mul: multiplicand magnitude; div: divisor magnitude
    logic [31:0] rs_q, rs_d;       // raw rs, returned as HI on divide-by-zero
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;     // product / quotient sign
    logic        rneg_q, rneg_d;   // remainder sign
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Instruction decode.
    logic [5:0]  op, func;
    logic        is_r, is_mul, is_div, is_signed, hilo_cls, start_seq;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign op        = Ins[31:26];
    assign func      = Ins[5:0];
    assign is_r      = (op == R_FORM);
    assign is_mul    = is_r && ((func == MULT) || (func == MULTU));
    assign is_div    = is_r && ((func == DIV)  || (func == DIVU));
    assign is_signed = (func == MULT) || (func == DIV);
    assign hilo_cls  = is_r && ((func == MFHI) || (func == MFLO) || (func == MTHI) ||
                                (func == MTLO) || is_mul || is_div);

    assign Busy  = (state_q != S_IDLE);
    assign Stall = Busy & hilo_cls;
    assign HI    = hi_q;
    assign LO    = lo_q;

    // Operand magnitudes; unsigned forms pass through untouched.
    assign a_neg = is_signed & Rdata1[31];
    assign b_neg = is_signed & Rdata2[31];
    assign a_mag = a_neg ? (32'd0 - Rdata1) : Rdata1;
    assign b_mag = b_neg ? (32'd0 - Rdata2) : Rdata2;

`ifdef HILO_FAST_MUL_EN
    logic [63:0] a_ext, b_ext, fast_prod;
    // Both operands extended to 64 bits; the low 64 bits of the product are
    // the correct two's-complement result for signed and unsigned forms.
    assign a_ext     = {{32{is_signed & Rdata1[31]}}, Rdata1};
    assign b_ext     = {{32{is_signed & Rdata2[31]}}, Rdata2};
    assign fast_prod = a_ext * b_ext;
    assign start_seq = is_div;
`else
    assign start_seq = is_mul | is_div;
`endif

    // Writeback select: loads, then links, then HI/LO moves, then ALU.
    // JALR is the R-form link (function 001001), not a primary opcode.
    always_comb begin
        Wdata = AluResult;
        if (op == LW)
            Wdata = MemData;
        else if ((op == JAL) || (is_r && (func == JALR)))
            Wdata = PC4;
        else if (is_r && (func == MFHI))
            Wdata = hi_q;
        else if (is_r && (func == MFLO))
            Wdata = lo_q;
    end

    // One sequencer step: shift-add for multiply, restoring subtract for divide.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, prod_q[31:1]};
        div_shift = prod_q[63:31];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_ge ? {div_diff[31:0], prod_q[30:0], 1'b1}
                           : {prod_q[62:0], 1'b0};
    end

    // Sign fix-up of the finished magnitudes.
    logic [63:0] mul_res;
    logic [31:0] quo_res, rem_res;

    always_comb begin
        mul_res = neg_q  ? (64'd0 - prod_q) : prod_q;
        quo_res = neg_q  ? (32'd0 - prod_q[31:0])  : prod_q[31:0];
        rem_res = rneg_q ? (32'd0 - prod_q[63:32]) : prod_q[63:32];
    end

    // Next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        rs_d     = rs_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_r && (func == MTHI))
                    hi_d = Rdata1;
                if (is_r && (func == MTLO))
                    lo_d = Rdata1;
`ifdef HILO_FAST_MUL_EN
                if (is_mul) begin
                    hi_d = fast_prod[63:32];
                    lo_d = fast_prod[31:0];
                end
`endif
                if (start_seq) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd0;
                    is_div_d = is_div;
                    rs_d     = Rdata1;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    if (is_div) begin
                        prod_d = {32'd0, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        prod_d = {32'd0, b_mag};
                        opnd_d = a_mag;
                    end
                end
            end
            S_RUN: begin
                prod_d = is_div_q ? div_next : mul_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
                if (!is_div_q) begin
                    hi_d = mul_res[63:32];
                    lo_d = mul_res[31:0];
                end else if (opnd_q == 32'd0) begin
                    hi_d = rs_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            prod_q   <= 64'd0;
            opnd_q   <= 32'd0;
            rs_q     <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            rs_q     <= rs_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Instruction fields not needed here (register specifiers, shamt).
    logic unused_bits;
    assign unused_bits = ^{Ins[25:6], div_diff[32]};

endmodule

// File: tb/tb_hilo_wb_unit.sv
// Scoreboard bench for hilo_wb_unit: stimulus pushes expected values, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_hilo_wb_unit;

    logic        CLK, RST;
    logic [31:0] Ins, Rdata1, Rdata2, AluResult, MemData, PC4;
    logic [31:0] Wdata, HI, LO;
    logic        Stall, Busy;

    hilo_wb_unit dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2),
        .AluResult(AluResult), .MemData(MemData), .PC4(PC4),
        .Wdata(Wdata), .Stall(Stall), .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int SEL_WDATA = 0, SEL_HI = 1, SEL_LO = 2, SEL_BUSY = 3, SEL_STALL = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every expectation queued for this cycle is checked at negedge.
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                SEL_WDATA: act = Wdata;
                SEL_HI:    act = HI;
                SEL_LO:    act = LO;
                SEL_BUSY:  act = {31'd0, Busy};
                default:   act = {31'd0, Stall};
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    function automatic logic [31:0] rf(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic chk();
        @(negedge CLK); #1;
    endtask

    // Issue a sequencer op, confirm 33 busy cycles, then check HI/LO.
    task automatic seq_op(input string name, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        step();
        Ins = ins; Rdata1 = a; Rdata2 = b;
        expect_v({name, "_issue_stall"}, SEL_STALL, 32'd0);
        expect_v({name, "_issue_busy"}, SEL_BUSY, 32'd0);
        chk();
        step();
        Ins = 32'd0;
        for (int i = 0; i < 33; i++) begin
            expect_v({name, "_busy"}, SEL_BUSY, 32'd1);
            chk();
            step();
        end
        expect_v({name, "_done_busy"}, SEL_BUSY, 32'd0);
        expect_v({name, "_hi"}, SEL_HI, ehi);
        expect_v({name, "_lo"}, SEL_LO, elo);
        chk();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; Ins = 32'd0; Rdata1 = 32'd0; Rdata2 = 32'd0;
        AluResult = 32'h55; MemData = 32'd0; PC4 = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        expect_v("rst_hi", SEL_HI, 32'd0);
        expect_v("rst_lo", SEL_LO, 32'd0);
        expect_v("rst_busy", SEL_BUSY, 32'd0);
        expect_v("rst_stall", SEL_STALL, 32'd0);
        expect_v("rst_wdata_alu", SEL_WDATA, 32'h55);
        chk();

        // Writeback mux and HI/LO moves.
        step();
        Ins = {6'b100011, 26'd0}; MemData = 32'hCAFE0001;
        expect_v("lw_wdata", SEL_WDATA, 32'hCAFE0001);
        chk();
        step();
        Ins = {6'b000011, 26'd0}; PC4 = 32'h404;
        expect_v("jal_wdata", SEL_WDATA, 32'h404);
        chk();
        step();
        Ins = rf(6'b010001); Rdata1 = 32'h1234;
        expect_v("mthi_stall", SEL_STALL, 32'd0);
        chk();
        step();
        Ins = rf(6'b010000);
        expect_v("mfhi_hi", SEL_HI, 32'h1234);
        expect_v("mfhi_wdata", SEL_WDATA, 32'h1234);
        chk();
        step();
        Ins = rf(6'b010011); Rdata1 = 32'hABCD;
        chk();
        step();
        Ins = rf(6'b010010);
        expect_v("mflo_wdata", SEL_WDATA, 32'hABCD);
        expect_v("mtlo_hi_kept", SEL_HI, 32'h1234);
        chk();

`ifndef HILO_FAST_MUL_EN
        // MULTU with a dependent MFLO waiting behind it.
        step();
        Ins = rf(6'b011001); Rdata1 = 32'hFFFFFFFF; Rdata2 = 32'd2;
        expect_v("multu_issue_stall", SEL_STALL, 32'd0);
        chk();
        step();
        Ins = rf(6'b010010);
        for (int i = 0; i < 33; i++) begin
            expect_v("multu_busy", SEL_BUSY, 32'd1);
            expect_v("mflo_stall", SEL_STALL, 32'd1);
            chk();
            step();
        end
        expect_v("multu_busy_end", SEL_BUSY, 32'd0);
        expect_v("mflo_go", SEL_STALL, 32'd0);
        expect_v("multu_hi", SEL_HI, 32'h00000001);
        expect_v("multu_lo", SEL_LO, 32'hFFFFFFFE);
        expect_v("multu_mflo", SEL_WDATA, 32'hFFFFFFFE);
        chk();

        seq_op("mult_m3x5", rf(6'b011000), 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        seq_op("multu_big", rf(6'b011001), 32'h80000000, 32'h80000000, 32'h40000000, 32'd0);
`else
        step();
        Ins = rf(6'b011000); Rdata1 = 32'd6; Rdata2 = 32'd7;
        expect_v("fmul_busy", SEL_BUSY, 32'd0);
        expect_v("fmul_stall", SEL_STALL, 32'd0);
        chk();
        step();
        Ins = 32'd0;
        expect_v("fmul_lo", SEL_LO, 32'd42);
        expect_v("fmul_hi", SEL_HI, 32'd0);
        expect_v("fmul_busy_after", SEL_BUSY, 32'd0);
        chk();
`endif

        seq_op("div_m7by2", rf(6'b011010), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        seq_op("div_ovf", rf(6'b011010), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        seq_op("div_m5by0", rf(6'b011010), 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        seq_op("divu_100by7", rf(6'b011011), 32'd100, 32'd7, 32'd2, 32'd14);
        seq_op("divu_7by0", rf(6'b011011), 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);

        // Reset in cycle 10 of a DIV clears everything at once.
        step();
        Ins = rf(6'b011010); Rdata1 = 32'd100; Rdata2 = 32'd3;
        chk();
        step();
        Ins = 32'd0;
        repeat (9) step();
        expect_v("rstmid_busy_before", SEL_BUSY, 32'd1);
        expect_v("rstmid_hi_before", SEL_HI, 32'd7);
        chk();
        step();
        RST = 1'b0; Ins = rf(6'b010000);
        expect_v("rstmid_hi", SEL_HI, 32'd0);
        expect_v("rstmid_lo", SEL_LO, 32'd0);
        expect_v("rstmid_busy", SEL_BUSY, 32'd0);
        expect_v("rstmid_stall", SEL_STALL, 32'd0);
        chk();
        step();
        RST = 1'b1;
        expect_v("post_rst_mfhi", SEL_WDATA, 32'd0);
        expect_v("post_rst_stall", SEL_STALL, 32'd0);
        chk();

        step();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
